multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk (rising edge) and rst_n.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 ALUSrcB  output  2  00=regB, 01=const 4, 10=sign-extended imm, 11=imm<<2.
REQ-008 PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-009 ALUOp  output  3  000=and, 001=or, 010=add, 011=sub, 100=R-type funct.
REQ-010 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-011 Moore FSM; all outputs SHALL be a pure decode of the current state.
REQ-012 States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP.
REQ-013 IDLE: all outputs 0; unconditional transition to FETCH.
REQ-014 FETCH: MemRead=1, IorD=0, IRWrite=mem_ready, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00, PCWrite=mem_ready; hold in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=010; latch opcode into an internal register; all later states SHALL use the latched value only.
REQ-016 DECODE dispatch: 000000->REX, 001000/001100/001101->IEX, 100011/101011->MEMADR, 000100->BEQ, 000010->JMP; any other opcode->FETCH with illegal_op=1 in that DECODE cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=010; lw->MEMRD, sw->MEMWR.
REQ-018 MEMRD: MemRead=1, IorD=1; hold until mem_ready, then MEMWB.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then FETCH.
REQ-021 REX: ALUSrcA=1, ALUSrcB=00, ALUOp=100; then RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
REQ-022 IEX: ALUSrcA=1, ALUSrcB=10, ALUOp=010 (addi), 000 (andi) or 001 (ori); then IWB. IWB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
REQ-023 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=011, PCWriteCond=1, PCSource=01; then FETCH.
REQ-024 JMP: PCWrite=1, PCSource=10; then FETCH.
REQ-025 With mem_ready held at 1, the cycles per instruction SHALL be: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3; each cycle mem_ready is low in a wait state adds exactly one cycle.
REQ-026 MemRead and MemWrite SHALL never be asserted in the same cycle; RegWrite SHALL never be asserted in FETCH or DECODE.
REQ-027 opcode changes outside the DECODE cycle SHALL have no effect.

Reset
REQ-028 rst_n low SHALL force the state to IDLE asynchronously, from any state including memory wait states, and SHALL clear the latched opcode to 000000.
REQ-029 While rst_n is low, every output SHALL be 0.
REQ-030 The first FETCH SHALL occur on the second rising clk edge after rst_n deasserts.

Structure
REQ-031 Package mc_pkg SHALL hold the state enumeration, the opcode constants, and the ALUOp and ALUSrcB/PCSource encodings.
REQ-032 One sub-module, mc_opcode_decode, SHALL map the latched opcode to an instruction class and the IEX ALUOp; it SHALL be combinational.

Verification
REQ-033 Reset release, mem_ready=1, opcode=000000: states IDLE,FETCH,DECODE,REX,RWB,FETCH; RWB has RegWrite=1 and RegDst=1.
REQ-034 lw (100011) with mem_ready low for 2 cycles in MEMRD: MEMRD lasts 3 cycles; MEMWB has RegWrite=1 and MemtoReg=1; total 7 cycles.
REQ-035 ori (001101): IEX has ALUOp=001 and ALUSrcB=10; opcode changed to 000100 during IEX still yields IWB.
REQ-036 opcode=111111 at DECODE: illegal_op=1 for exactly that cycle, next state FETCH, no RegWrite/MemWrite pulse.
REQ-037 rst_n asserted mid-MEMWR with mem_ready=0: all outputs 0 immediately without a clock edge, and MemWrite is never seen after release until a new sw.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: states, opcodes,
// instruction classes and the datapath select/ALU encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_REX,
        ST_RWB,
        ST_IEX,
        ST_IWB,
        ST_BEQ,
        ST_JMP
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_FUNCT = 3'b100;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: instruction class plus the ALU operation
// used by the immediate-execute state.
module mc_opcode_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    output iclass_t    iclass,
    output logic [2:0] imm_aluop
);

    always_comb begin
        iclass    = CLS_ILLEGAL;
        imm_aluop = ALU_ADD;
        case (op)
            OP_RTYPE: iclass = CLS_RTYPE;
            OP_ADDI: begin
                iclass    = CLS_IMM;
                imm_aluop = ALU_ADD;
            end
            OP_ANDI: begin
                iclass    = CLS_IMM;
                imm_aluop = ALU_AND;
            end
            OP_ORI: begin
                iclass    = CLS_IMM;
                imm_aluop = ALU_OR;
            end
            OP_LW:   iclass = CLS_LOAD;
            OP_SW:   iclass = CLS_STORE;
            OP_BEQ:  iclass = CLS_BRANCH;
            OP_J:    iclass = CLS_JUMP;
            default: iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath select and enable lines from the current state.
module multicycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       illegal_op
);

    state_t     state, next_state;
    logic       armed;
    logic [5:0] opcode_q;
    logic [5:0] dec_op;
    iclass_t    iclass;
    logic [2:0] imm_aluop;

    // Dispatch happens in DECODE while the register is still being loaded,
    // so that one cycle looks at the live opcode; every later state sees the latch.
    assign dec_op = (state == ST_DECODE) ? opcode : opcode_q;

    mc_opcode_decode u_decode (
        .op        (dec_op),
        .iclass    (iclass),
        .imm_aluop (imm_aluop)
    );

    // armed delays leaving IDLE by one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            armed    <= 1'b0;
            opcode_q <= 6'b000000;
        end else begin
            state <= next_state;
            armed <= 1'b1;
            if (state == ST_DECODE)
                opcode_q <= opcode;
        end
    end

    always_comb begin
        next_state  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALU_AND;
        illegal_op  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed)
                    next_state = ST_FETCH;
            end
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)
                    next_state = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                ALUOp   = ALU_ADD;
                case (iclass)
                    CLS_RTYPE:  next_state = ST_REX;
                    CLS_IMM:    next_state = ST_IEX;
                    CLS_LOAD,
                    CLS_STORE:  next_state = ST_MEMADR;
                    CLS_BRANCH: next_state = ST_BEQ;
                    CLS_JUMP:   next_state = ST_JMP;
                    default: begin
                        next_state = ST_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALU_ADD;
                next_state = (iclass == CLS_LOAD) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)
                    next_state = ST_MEMWB;
            end
            ST_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                next_state = ST_FETCH;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready)
                    next_state = ST_FETCH;
            end
            ST_REX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_REGB;
                ALUOp      = ALU_FUNCT;
                next_state = ST_RWB;
            end
            ST_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_IEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = imm_aluop;
                next_state = ST_IWB;
            end
            ST_IWB: begin
                RegWrite   = 1'b1;
                next_state = ST_FETCH;
            end
            ST_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REGB;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                next_state  = ST_FETCH;
            end
            ST_JMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                next_state = ST_FETCH;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule
